// File: rtl/ift_mem_req_queue.sv
// Taint-aware memory request queue between the core memory port and the SRAM model.
// Buffers up to Depth requests and relocates byte addresses to SRAM word addresses.
// Issues at most one request per cycle downstream. Each data-path field carries its
// taint sidecar through the queue.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   core_*_i / core_*_o    core request channel (req/gnt/addr/we/wdata/strb) and response
//                          channel (rvalid/rdata/err); *_t0 are the matching taints
//   sram_stall_i           downstream backpressure, blocks issue while high
//   sram_*_o               word-addressed SRAM request, driven combinationally from the head
//   sram_rdata_i(_t0)      SRAM read data, valid one cycle after a read issue
module ift_mem_req_queue #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumWords  = 1 << 20,
  parameter logic [AddrWidth-1:0] BaseAddr = AddrWidth'(64'h8000_0000),
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_req_i,
  output logic                 core_gnt_o,
  input  logic [AddrWidth-1:0] core_addr_i,
  input  logic                 core_we_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic [StrbWidth-1:0] core_strb_i,
  input  logic                 core_req_i_t0,
  input  logic [AddrWidth-1:0] core_addr_i_t0,
  input  logic                 core_we_i_t0,
  input  logic [DataWidth-1:0] core_wdata_i_t0,
  input  logic [StrbWidth-1:0] core_strb_i_t0,
  output logic                 core_gnt_o_t0,
  output logic                 core_rvalid_o,
  output logic [DataWidth-1:0] core_rdata_o,
  output logic [DataWidth-1:0] core_rdata_o_t0,
  output logic                 core_err_o,
  input  logic                 sram_stall_i,
  output logic                 sram_req_o,
  output logic                 sram_write_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [DataWidth-1:0] sram_wmask_o,
  output logic                 sram_req_o_t0,
  output logic                 sram_write_o_t0,
  output logic [AddrWidth-1:0] sram_addr_o_t0,
  output logic [DataWidth-1:0] sram_wdata_o_t0,
  output logic [DataWidth-1:0] sram_wmask_o_t0,
  input  logic [DataWidth-1:0] sram_rdata_i,
  input  logic [DataWidth-1:0] sram_rdata_i_t0
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam int unsigned OffW = $clog2(StrbWidth);

  // Entry storage, one slot per queue position
  logic [AddrWidth-1:0] r_addr     [Depth];
  logic [AddrWidth-1:0] r_addr_t0  [Depth];
  logic [DataWidth-1:0] r_wdata    [Depth];
  logic [DataWidth-1:0] r_wdata_t0 [Depth];
  logic [StrbWidth-1:0] r_strb     [Depth];
  logic [StrbWidth-1:0] r_strb_t0  [Depth];
  logic [Depth-1:0]     r_we;
  logic [Depth-1:0]     r_we_t0;
  logic [Depth-1:0]     r_req_t0;

  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;
  logic            r_rvalid;
  logic            r_rerr;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_in_range;
  logic [AddrWidth-1:0] w_word;
  logic [AddrWidth-1:0] w_head_addr;
  logic                 w_head_we;
  logic [DataWidth-1:0] w_wmask;
  logic [DataWidth-1:0] w_wmask_t0;

  // Grant is derived from the registered count only, so a same-cycle pop at full does not reopen it
  assign core_gnt_o    = (r_count != CntW'(Depth));
  assign core_gnt_o_t0 = 1'b0;

  assign w_push      = core_req_i & core_gnt_o;
  assign w_pop       = (r_count != '0) & ~sram_stall_i;
  assign w_head_addr = r_addr[r_head];
  assign w_head_we   = r_we[r_head];

  // Modular subtraction: addresses below BaseAddr wrap high and are caught by the >= test
  assign w_word     = (w_head_addr - BaseAddr) >> OffW;
  assign w_in_range = (w_head_addr >= BaseAddr) && (w_word < AddrWidth'(NumWords));
  assign w_issue    = w_pop & w_in_range;

  // Entry write port; payload needs no reset since count qualifies every read
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_tail]     <= core_addr_i;
      r_addr_t0[r_tail]  <= core_addr_i_t0;
      r_wdata[r_tail]    <= core_wdata_i;
      r_wdata_t0[r_tail] <= core_wdata_i_t0;
      r_strb[r_tail]     <= core_strb_i;
      r_strb_t0[r_tail]  <= core_strb_i_t0;
      r_we[r_tail]       <= core_we_i;
      r_we_t0[r_tail]    <= core_we_i_t0;
      r_req_t0[r_tail]   <= core_req_i_t0;
    end
  end

  // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PtrW'(1);
      if (w_pop)  r_head <= r_head + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response tracking: one cycle after a read pops, flag whether it is a real or error response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
    end else begin
      r_rvalid <= w_pop & ~w_head_we;
      r_rerr   <= w_pop & ~w_head_we & ~w_in_range;
    end
  end

  assign core_rvalid_o   = r_rvalid;
  assign core_err_o      = r_rerr;
  assign core_rdata_o    = (r_rvalid & ~r_rerr) ? sram_rdata_i    : '0;
  assign core_rdata_o_t0 = (r_rvalid & ~r_rerr) ? sram_rdata_i_t0 : '0;

  // Byte strobes to bit masks, data and taint alike
  always_comb begin
    w_wmask    = '0;
    w_wmask_t0 = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      w_wmask[i*8 +: 8]    = {8{r_strb[r_head][i]}};
      w_wmask_t0[i*8 +: 8] = {8{r_strb_t0[r_head][i]}};
    end
  end

  // Downstream request: head entry when issuing in range, all zero otherwise
  always_comb begin
    sram_req_o      = 1'b0;
    sram_write_o    = 1'b0;
    sram_addr_o     = '0;
    sram_wdata_o    = '0;
    sram_wmask_o    = '0;
    sram_req_o_t0   = 1'b0;
    sram_write_o_t0 = 1'b0;
    sram_addr_o_t0  = '0;
    sram_wdata_o_t0 = '0;
    sram_wmask_o_t0 = '0;
    if (w_issue) begin
      sram_req_o      = 1'b1;
      sram_write_o    = w_head_we;
      sram_addr_o     = w_word;
      sram_wdata_o    = r_wdata[r_head];
      sram_wmask_o    = w_wmask;
      sram_req_o_t0   = r_req_t0[r_head];
      sram_write_o_t0 = r_we_t0[r_head];
      sram_addr_o_t0  = r_addr_t0[r_head] >> OffW;
      sram_wdata_o_t0 = r_wdata_t0[r_head];
      sram_wmask_o_t0 = w_wmask_t0;
    end
  end

endmodule

// File: doc/ift_mem_req_queue.md
Name: ift_mem_req_queue

Overview:
- Taint-aware request queue between the core memory port (`mem_req`/`mem_gnt`/`mem_rdata` plus `_t0` taints) and the SRAM model (`ift_sram_mem`).
- Generates the core grant, buffers up to Depth requests and relocates byte addresses to SRAM word addresses.
- Issues at most one request per cycle downstream and returns read data with a valid strobe.
- Every data-path field carries its taint sidecar through the queue unchanged.

Parameters:
- Depth, 4, queue entries; power of 2, at least 2.
- AddrWidth, 64, core byte-address width.
- DataWidth, 64, data width; StrbWidth = DataWidth/8.
- NumWords, 1<<20, SRAM depth in words.
- BaseAddr, 64'h80000000, byte address mapped to SRAM word 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core request
- core_gnt_o  out  1  grant; a request is accepted when core_req_i && core_gnt_o
- core_addr_i  in  AddrWidth  byte address
- core_we_i  in  1  write enable
- core_wdata_i  in  DataWidth  write data
- core_strb_i  in  StrbWidth  byte strobes
- core_req_i_t0, core_addr_i_t0, core_we_i_t0, core_wdata_i_t0, core_strb_i_t0  in  same widths as above  taints
- core_gnt_o_t0  out  1  taint of grant; constant 0
- core_rvalid_o  out  1  read response valid
- core_rdata_o  out  DataWidth  read data
- core_rdata_o_t0  out  DataWidth  read data taint
- core_err_o  out  1  read response is for an out-of-range address
- sram_stall_i  in  1  downstream backpressure; no issue while high
- sram_req_o  out  1  SRAM request
- sram_write_o  out  1  SRAM write
- sram_addr_o  out  AddrWidth  word address
- sram_wdata_o  out  DataWidth  write data
- sram_wmask_o  out  DataWidth  bit mask
- sram_req_o_t0, sram_write_o_t0, sram_addr_o_t0, sram_wdata_o_t0, sram_wmask_o_t0  out  same widths  taints
- sram_rdata_i  in  DataWidth  read data, valid one cycle after a read issue
- sram_rdata_i_t0  in  DataWidth  read data taint

Behaviour:
- Reset (async, rst_ni low): head, tail and count = 0.
  - core_gnt_o = 1.
  - All sram_* outputs, their taints, core_rvalid_o, core_err_o, core_rdata_o and core_rdata_o_t0 = 0.
  - A pending read response is discarded; no rvalid after reset release.
- Grant: core_gnt_o = (count != Depth).
  - Derived from the registered count only.
  - At full, grant stays 0 even if a pop occurs in the same cycle.
- Push on accept: store addr, we, wdata, strb and all five taints at tail; tail wraps modulo Depth.
  - core_req_i_t0 is stored but does not gate acceptance.
- Issue: when count != 0 and !sram_stall_i, pop head.
  - Outputs are combinational from the head entry.
  - Push and pop in the same cycle leave count unchanged.
- Address relocation: word = (addr - BaseAddr) >> 3, using modular AddrWidth subtraction.
  - Taint: sram_addr_o_t0 = addr_t0 >> 3.
- Range check: in range iff addr >= BaseAddr and word < NumWords.
- In-range entry: sram_req_o = 1, sram_write_o = we.
  - Each byte lane of sram_wmask_o = {8{strb[i]}}; the same expansion applies to the taint.
- Out-of-range entry: popped with sram_req_o = 0.
  - A write is dropped silently.
  - A read schedules an error response.
- Response: 1 cycle after popping a read, core_rvalid_o = 1.
  - In range: core_rdata_o = sram_rdata_i, core_rdata_o_t0 = sram_rdata_i_t0, core_err_o = 0.
  - Out of range: rdata = 0, rdata_t0 = 0, core_err_o = 1.
  - Writes produce no response.
- Responses return in request order; maximum one per cycle.
- sram_req_o_t0 = req_t0 of the head entry, gated by the in-range condition.
- sram_write_o_t0 = we_t0 of the head entry, under the same gating.
- Between issues, sram_* outputs and taints are 0.

Test Plan:
- Reset, then write addr 0x80000010, wdata 0xDEADBEEF, strb 0x0F, stall=0 -> sram_addr_o=2 on the same cycle as accept+1; wmask=0x00000000FFFFFFFF; no rvalid.
- Read 0x80000010 with sram_rdata_i=0x1234 and taint 0xFF one cycle after issue -> rvalid=1, rdata=0x1234, rdata_t0=0xFF, err=0.
- Hold stall=1 and push 4 requests -> gnt drops to 0 after the 4th accept; release stall -> 4 issues on consecutive cycles in order; gnt returns after the first pop.
- Read 0x7FFFFFF8 and read 0x80000000+8*NumWords -> no sram_req_o; each gives rvalid=1, err=1, rdata=0.
- Push with addr_t0=0x18 and wdata_t0=0xF0 -> sram_addr_o_t0=0x3, sram_wdata_o_t0=0xF0.
- Assert rst_ni low with 2 reads queued, one in flight -> all outputs 0 immediately; after release, gnt=1 and no stale rvalid.
